// File: rtl/ped_light_pkg.sv
// Shared types, constants and the binary-to-BCD helper for the pedestrian light.
package ped_light_pkg;

    typedef enum logic [1:0] {
        RED  = 2'd0,
        WALK = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Standing figure shown on the dot matrix while the light is red.
    localparam logic [1:0] FRAME_STAND = 2'b00;

    // Double-dabble conversion of a 7-bit value into two BCD digits {tens, ones}.
    // Values are bounded to 0..99, so the tens digit never needs a hundreds carry.
    function automatic logic [7:0] bin2bcd(input logic [6:0] bin);
        logic [14:0] sr;
        sr = {8'd0, bin};
        for (int i = 0; i < 7; i++) begin
            if (sr[10:7] >= 4'd5)  sr[10:7]  = sr[10:7]  + 4'd3;
            if (sr[14:11] >= 4'd5) sr[14:11] = sr[14:11] + 4'd3;
            sr = sr << 1;
        end
        return sr[14:7];
    endfunction

endpackage

// File: rtl/ped_light_sec_prescaler.sv
// Per-second prescaler: counts 0..CLK_PER_SEC-1 while enabled and flags the last cycle.
module sec_prescaler #(
    parameter int CLK_PER_SEC = 1000,
    localparam int CW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] sec_cnt,
    output logic          sec_tick
);

    localparam logic [CW-1:0] LAST = CW'(CLK_PER_SEC - 1);

    logic [CW-1:0] sec_cnt_q, sec_cnt_d;

    // Tick only while enabled so a frozen counter cannot produce a second boundary.
    always_comb begin
        sec_tick  = en && (sec_cnt_q == LAST);
        sec_cnt_d = sec_cnt_q;
        if (en) sec_cnt_d = sec_tick ? '0 : sec_cnt_q + 1'b1;
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) sec_cnt_q <= '0;
        else     sec_cnt_q <= sec_cnt_d;
    end

    assign sec_cnt = sec_cnt_q;

endmodule

// File: rtl/ped_light_ctrl.sv
// Pedestrian light phase controller: RED -> WALK -> RUN countdown, lamp,
// animation-control, frame and BCD digit outputs, all registered from next-state values.
module ped_light_ctrl
    import ped_light_pkg::*;
#(
    parameter int CLK_PER_SEC = 1000,
    parameter int RED_SEC     = 30,
    parameter int WALK_SEC    = 20,
    parameter int RUN_SEC     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       hold,
    input  logic [1:0] sel,
    output logic       pause,
    output logic       quick,
    output logic       red_lamp,
    output logic       green_lamp,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic [1:0] frame
);

    localparam int CW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CW-1:0] HALF   = CW'(CLK_PER_SEC / 2);
    localparam logic [6:0]    RED_D  = 7'(RED_SEC);
    localparam logic [6:0]    WALK_D = 7'(WALK_SEC);
    localparam logic [6:0]    RUN_D  = 7'(RUN_SEC);
    localparam logic [6:0]    SHORT  = 7'd5;

    logic [CW-1:0] sec_cnt, sec_cnt_nxt;
    logic          sec_tick;

    state_t     state_q, state_d;
    logic [6:0] remain_q, remain_d;
    logic       pause_q, pause_d, quick_q, quick_d;
    logic       red_q, red_d, green_q, green_d;
    logic [1:0] frame_q, frame_d;
    logic [7:0] digits_q, digits_d;

    sec_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_presc (
        .clk      (clk),
        .rst      (rst),
        .en       (!hold),
        .sec_cnt  (sec_cnt),
        .sec_tick (sec_tick)
    );

    // Phase sequencing and countdown; hold freezes everything, the button
    // shortening beats the per-second decrement, and remain==1 hands over to the next phase.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        if (!hold) begin
            if (state_q == RED && ped_req && remain_q > SHORT) begin
                remain_d = SHORT;
            end else if (sec_tick) begin
                if (remain_q == 7'd1) begin
                    case (state_q)
                        RED:     begin state_d = WALK; remain_d = WALK_D; end
                        WALK:    begin state_d = RUN;  remain_d = RUN_D;  end
                        default: begin state_d = RED;  remain_d = RED_D;  end
                    endcase
                end else begin
                    remain_d = remain_q - 7'd1;
                end
            end
        end
    end

    // Output decode from next-state values; the flash phase uses the prescaler's next count
    // so a frozen counter keeps the green lamp where it is.
    always_comb begin
        sec_cnt_nxt = sec_cnt;
        if (!hold) sec_cnt_nxt = sec_tick ? '0 : sec_cnt + 1'b1;
        pause_d  = (state_d == RED) || hold;
        quick_d  = (state_d == RUN);
        red_d    = (state_d == RED);
        green_d  = (state_d == WALK) || (state_d == RUN && sec_cnt_nxt < HALF);
        frame_d  = (state_d == RED) ? FRAME_STAND : sel;
        digits_d = bin2bcd(remain_d);
    end

    // State, countdown and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RED;
            remain_q <= RED_D;
            pause_q  <= 1'b1;
            quick_q  <= 1'b0;
            red_q    <= 1'b1;
            green_q  <= 1'b0;
            frame_q  <= FRAME_STAND;
            digits_q <= bin2bcd(RED_D);
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            pause_q  <= pause_d;
            quick_q  <= quick_d;
            red_q    <= red_d;
            green_q  <= green_d;
            frame_q  <= frame_d;
            digits_q <= digits_d;
        end
    end

    assign pause      = pause_q;
    assign quick      = quick_q;
    assign red_lamp   = red_q;
    assign green_lamp = green_q;
    assign frame      = frame_q;
    assign cnt_tens   = digits_q[7:4];
    assign cnt_ones   = digits_q[3:0];

endmodule

// File: tb/tb_ped_light_ctrl.sv
// Scoreboard bench for ped_light_ctrl with a 4-cycle second, 6/2/2 second phases.
module tb_ped_light_ctrl;

    localparam int CPS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ped_req = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       pause, quick, red_lamp, green_lamp;
    logic [3:0] cnt_tens, cnt_ones;
    logic [1:0] frame;

    typedef struct packed {
        logic       pause;
        logic       quick;
        logic       red;
        logic       green;
        logic [3:0] tens;
        logic [3:0] ones;
        logic [1:0] frame;
    } out_t;

    typedef struct {
        out_t  v;
        string nm;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0, errors = 0, pushed = 0, popped = 0;
    logic [1:0] sp = 2'd0;
    out_t       act;
    exp_t       cur;

    ped_light_ctrl #(.CLK_PER_SEC(CPS), .RED_SEC(6), .WALK_SEC(2), .RUN_SEC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ped_req    (ped_req),
        .hold       (hold),
        .sel        (sel),
        .pause      (pause),
        .quick      (quick),
        .red_lamp   (red_lamp),
        .green_lamp (green_lamp),
        .cnt_tens   (cnt_tens),
        .cnt_ones   (cnt_ones),
        .frame      (frame)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic p, input logic q, input logic r, input logic g,
                                input int d, input logic [1:0] f);
        out_t o;
        o.pause = p; o.quick = q; o.red = r; o.green = g;
        o.tens  = 4'(d / 10);
        o.ones  = 4'(d % 10);
        o.frame = f;
        return o;
    endfunction

    // Drive one cycle of inputs, then queue what the DUT must show after that edge.
    task automatic step(input logic r, input logic pr, input logic h, input logic [1:0] s,
                        input out_t e, input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; ped_req = pr; hold = h; sel = s;
        @(posedge clk);
        x.v = e; x.nm = nm;
        sb.push_back(x);
        pushed++;
    endtask

    task automatic do_reset(input string nm);
        step(1'b1, 1'b0, 1'b0, sp, mk(1, 0, 1, 0, 6, 2'd0), nm);
    endtask

    task automatic red_secs(input int d, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            sp = sp + 2'd1;
            step(1'b0, 1'b0, 1'b0, sp, mk(1, 0, 1, 0, d, 2'd0), nm);
        end
    endtask

    task automatic walk_secs(input int d, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            sp = sp + 2'd1;
            step(1'b0, 1'b0, 1'b0, sp, mk(0, 0, 0, 1, d, sp), nm);
        end
    endtask

    // One RUN second: green on for the first half of the prescaler count.
    task automatic run_sec(input int d, input string nm);
        for (int i = 0; i < CPS; i++) begin
            sp = sp + 2'd1;
            step(1'b0, 1'b0, 1'b0, sp, mk(0, 1, 0, (i < CPS / 2), d, sp), nm);
        end
    endtask

    // Monitor: compare every queued expectation one half-cycle after its edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            popped++;
            checks++;
            act = {pause, quick, red_lamp, green_lamp, cnt_tens, cnt_ones, frame};
            if (act !== cur.v) begin
                errors++;
                $display("FAIL %s: got pause=%0b quick=%0b red=%0b green=%0b digits=%0d%0d frame=%0d, expected pause=%0b quick=%0b red=%0b green=%0b digits=%0d%0d frame=%0d",
                         cur.nm, act.pause, act.quick, act.red, act.green, act.tens, act.ones, act.frame,
                         cur.v.pause, cur.v.quick, cur.v.red, cur.v.green, cur.v.tens, cur.v.ones, cur.v.frame);
            end
        end
    end

    initial begin
        // Free-running cycle with sel sweeping every cycle.
        do_reset("reset values");
        red_secs(6, 3, "s1 red 6");
        for (int d = 5; d >= 1; d--) red_secs(d, 4, "s1 red countdown");
        walk_secs(2, 4, "s1 walk 2");
        walk_secs(1, 4, "s1 walk 1");
        run_sec(2, "s1 run 2");
        run_sec(1, "s1 run 1");
        red_secs(6, 4, "s1 back to red");

        // Button shortening, ignored presses, hold in WALK.
        do_reset("s2 reset");
        sp = sp + 2'd1;
        step(1'b0, 1'b1, 1'b0, sp, mk(1, 0, 1, 0, 5, 2'd0), "s2 ped shortens to 05");
        red_secs(5, 2, "s2 red 5");
        red_secs(4, 4, "s2 red 4");
        red_secs(3, 1, "s2 red 3");
        sp = sp + 2'd1;
        step(1'b0, 1'b1, 1'b0, sp, mk(1, 0, 1, 0, 3, 2'd0), "s3 ped at 3 ignored");
        red_secs(3, 2, "s3 red 3");
        red_secs(2, 4, "s3 red 2");
        red_secs(1, 4, "s3 red 1");
        walk_secs(2, 1, "s2 walk entry");
        sp = sp + 2'd1;
        step(1'b0, 1'b1, 1'b0, sp, mk(0, 0, 0, 1, 2, sp), "s3 ped in walk ignored");
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, 1'b1, sp, mk(1, 0, 0, 1, 2, sp), "s4 hold in walk");
        walk_secs(2, 2, "s4 walk resumes");
        walk_secs(1, 4, "s4 walk 1");

        // RUN with hold freezing the flash, then reset under hold.
        sp = sp + 2'd1;
        step(1'b0, 1'b0, 1'b0, sp, mk(0, 1, 0, 1, 2, sp), "s6 run entry");
        sp = sp + 2'd1;
        step(1'b0, 1'b0, 1'b0, sp, mk(0, 1, 0, 1, 2, sp), "s6 run green on");
        sp = sp + 2'd1;
        step(1'b0, 1'b0, 1'b0, sp, mk(0, 1, 0, 0, 2, sp), "s6 run green off");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, sp, mk(1, 1, 0, 0, 2, sp), "s6 hold freezes flash");
        step(1'b1, 1'b1, 1'b1, sp, mk(1, 0, 1, 0, 6, 2'd0), "s6 reset under hold");
        red_secs(6, 1, "s6 red after reset");

        @(negedge clk);
        #1;
        checks++;
        if (popped != pushed || sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d popped, expected %0d", popped, pushed);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
